glitch_reset_monitor: RTL and testbench
=======================================

GLITCH_RESET_MONITOR -- requirements
Module: glitch_reset_monitor

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on rst_sense (legal range 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the pulse-width counter and the delay counter.
REQ-003 The block SHALL have port clk_in, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port rst_sense, input, 1 bit: the target's reset line, active-low and asynchronous to clk_in.
REQ-006 The block SHALL have port arm, input, 1 bit: a single-cycle request to start monitoring.
REQ-007 The block SHALL have port abort, input, 1 bit: returns the block to IDLE.
REQ-008 The block SHALL have port min_width, input, 8 bits: the minimum low-pulse length, in cycles, that is accepted as a reset.
REQ-009 The block SHALL have port delay, input, CNT_W bits: the number of cycles from release detection to trigger.
REQ-010 The block SHALL have port trigger, output, 1 bit: a one-cycle pulse fired after an accepted reset release plus delay.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port pulse_width, output, CNT_W bits: the length of the last accepted low pulse.
REQ-013 The block SHALL have port width_valid, output, 1 bit: a one-cycle pulse issued when pulse_width updates.

Function
REQ-014 rst_sense SHALL pass through a SYNC_STAGES-flop synchronizer; the FSM SHALL use only the last stage (rs_sync).
REQ-015 The FSM SHALL have four states: IDLE, WAIT_LOW, LOW and DELAY.
REQ-016 In IDLE, arm=1 SHALL move the FSM to WAIT_LOW; arm SHALL be ignored in all other states.
REQ-017 In WAIT_LOW, rs_sync=0 SHALL move the FSM to LOW and load the width counter with 1; rs_sync=1 SHALL keep it in WAIT_LOW indefinitely.
REQ-018 In LOW, each edge with rs_sync=0 SHALL increment the width counter, saturating at all-ones with no wrap.
REQ-019 In LOW, if rs_sync=1 and width < min_width, the pulse SHALL be rejected: FSM to WAIT_LOW, no capture, no width_valid.
REQ-020 In LOW, if rs_sync=1 and width >= min_width, then on the same edge: pulse_width <= width; width_valid <= 1 for one cycle.
REQ-021 On that same accepted-release edge, if delay=0 then trigger <= 1 and FSM to IDLE; otherwise FSM to DELAY with the delay counter loaded with 1.
REQ-022 In DELAY, if the delay counter equals delay then trigger <= 1 and FSM to IDLE; otherwise the counter SHALL increment.
REQ-023 trigger SHALL rise exactly SYNC_STAGES+delay clk_in edges after the edge that first samples rst_sense high, and SHALL be high for exactly one cycle.
REQ-024 min_width=0 or 1 SHALL accept any low pulse of at least one synchronized cycle.
REQ-025 delay SHALL be sampled live in DELAY; changing it mid-count is undefined and is not verified.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge, suppress any trigger and width_valid on that edge, and leave pulse_width unchanged.
REQ-027 If abort and arm are both high in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-028 Only one trigger SHALL be produced per arm; re-arming SHALL be required for the next event.
REQ-029 busy SHALL be a registered decode of state != IDLE.

Reset
REQ-030 rst=1 SHALL, on the next edge, set: state IDLE, all counters 0, synchronizer flops 1 (deasserted target reset), trigger 0, width_valid 0, busy 0, pulse_width 0.
REQ-031 rst SHALL take priority over arm and abort, and SHALL apply mid-operation in any state with no trigger issued.

Verification
REQ-032 Scenario (nominal): SYNC_STAGES=2, min_width=8, delay=5; arm; rst_sense low for 20 cycles, then high -> width_valid pulse with pulse_width=20; trigger rises 7 edges after rst_sense is sampled high; busy then goes low.
REQ-033 Scenario (short glitch rejected): min_width=8; arm; rst_sense low 3 cycles -> no width_valid; busy stays high; a following 10-cycle low pulse -> pulse_width=10 and trigger.
REQ-034 Scenario (zero delay): delay=0, min_width=1; rst_sense low 1 cycle -> pulse_width=1; trigger rises 2 edges after the release sample.
REQ-035 Scenario (saturation): CNT_W=8; rst_sense low 300 cycles -> pulse_width=8'hFF; trigger still fires.
REQ-036 Scenario (abort/reset mid-operation): abort during DELAY -> no trigger and IDLE next cycle; separately, rst during LOW -> all outputs 0 and a later release produces nothing until re-armed.
REQ-037 Scenario (arm ignored while busy): arm pulsed in LOW and DELAY -> exactly one trigger in total.

Source files
------------

// File: rtl/glitch_reset_monitor.sv
// Glitch reset monitor: watches a target's active-low reset line, measures
// each low pulse, rejects glitches shorter than min_width, and fires a single
// trigger pulse a programmable number of cycles after an accepted release.
module glitch_reset_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             rst_sense,
   input  logic             arm,
   input  logic             abort,
   input  logic [7:0]       min_width,
   input  logic [CNT_W-1:0] delay,
   output logic             trigger,
   output logic             busy,
   output logic [CNT_W-1:0] pulse_width,
   output logic             width_valid
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_LOW = 2'd1,
      S_LOW      = 2'd2,
      S_DELAY    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   // Compare width against min_width at a width that holds both operands.
   localparam int CMP_W = (CNT_W > 8) ? CNT_W : 8;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rs_sync;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] width_q,  width_d;
   logic [CNT_W-1:0] dly_q,    dly_d;
   logic [CNT_W-1:0] pw_q,     pw_d;
   logic             trig_q,   trig_d;
   logic             wv_q,     wv_d;
   logic             busy_q,   busy_d;

   logic [CMP_W-1:0] width_ext;
   logic [CMP_W-1:0] minw_ext;
   logic             width_ok;

   assign rs_sync   = sync_q[SYNC_STAGES-1];
   assign width_ext = CMP_W'(width_q);
   assign minw_ext  = CMP_W'(min_width);
   // min_width of 0 or 1 accepts any pulse, since a counted pulse is >= 1.
   assign width_ok  = (width_ext >= minw_ext);

   // Synchronizer for the asynchronous target reset; idles high (released).
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rst_sense};
      end
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= S_IDLE;
         width_q <= CNT_ZERO;
         dly_q   <= CNT_ZERO;
         pw_q    <= CNT_ZERO;
         trig_q  <= 1'b0;
         wv_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         width_q <= width_d;
         dly_q   <= dly_d;
         pw_q    <= pw_d;
         trig_q  <= trig_d;
         wv_q    <= wv_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic: pulse measurement, glitch rejection and delay count.
   always_comb begin
      state_d = state_q;
      width_d = width_q;
      dly_d   = dly_q;
      pw_d    = pw_q;
      trig_d  = 1'b0;
      wv_d    = 1'b0;

      if (abort) begin
         // Abort dominates everything, including arm in IDLE; pulse_width is kept.
         state_d = S_IDLE;
         width_d = CNT_ZERO;
         dly_d   = CNT_ZERO;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_d = S_WAIT_LOW;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT_LOW: begin
               if (!rs_sync) begin
                  state_d = S_LOW;
                  width_d = CNT_ONE;
               end else begin
                  state_d = S_WAIT_LOW;
               end
            end
            S_LOW: begin
               if (!rs_sync) begin
                  // Saturate rather than wrap on very long pulses.
                  if (width_q != CNT_MAX) begin
                     width_d = width_q + CNT_ONE;
                  end else begin
                     width_d = width_q;
                  end
               end else if (!width_ok) begin
                  // Glitch: discard and keep waiting for a real reset.
                  state_d = S_WAIT_LOW;
                  width_d = CNT_ZERO;
               end else begin
                  pw_d    = width_q;
                  wv_d    = 1'b1;
                  width_d = CNT_ZERO;
                  if (delay == CNT_ZERO) begin
                     trig_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DELAY;
                     dly_d   = CNT_ONE;
                  end
               end
            end
            S_DELAY: begin
               if (dly_q == delay) begin
                  trig_d  = 1'b1;
                  state_d = S_IDLE;
                  dly_d   = CNT_ZERO;
               end else begin
                  dly_d = dly_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               width_d = CNT_ZERO;
               dly_d   = CNT_ZERO;
            end
         endcase
      end

      // busy follows the registered state exactly.
      busy_d = (state_d != S_IDLE);
   end

   assign trigger     = trig_q;
   assign busy        = busy_q;
   assign pulse_width = pw_q;
   assign width_valid = wv_q;

endmodule

// File: tb/tb_glitch_reset_monitor.sv
// Self-checking bench for glitch_reset_monitor: expected width_valid and
// trigger events are queued when a release is driven and retired by a monitor.
module tb_glitch_reset_monitor;

   localparam int SYNC  = 2;
   localparam int CW    = 8;

   logic          clk_in = 1'b0;
   logic          rst;
   logic          rst_sense;
   logic          arm;
   logic          abort;
   logic [7:0]    min_width;
   logic [CW-1:0] delay;
   logic          trigger;
   logic          busy;
   logic [CW-1:0] pulse_width;
   logic          width_valid;

   int cyc       = 0;
   int n_checks  = 0;
   int n_errors  = 0;

   int exp_wv_cyc[$];
   int exp_wv_w[$];
   int exp_trig_cyc[$];

   glitch_reset_monitor #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .rst_sense   (rst_sense),
      .arm         (arm),
      .abort       (abort),
      .min_width   (min_width),
      .delay       (delay),
      .trigger     (trigger),
      .busy        (busy),
      .pulse_width (pulse_width),
      .width_valid (width_valid)
   );

   // Clock generation.
   always #5 clk_in = ~clk_in;

   // Edge counter used to time expected events.
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Monitor: retire queued expectations whenever the DUT pulses an output.
   always @(negedge clk_in) begin
      if (width_valid) begin
         if (exp_wv_cyc.size() == 0) begin
            chk_eq("width_valid_unexpected", 1, 0);
         end else begin
            chk_eq("width_valid_cycle", cyc, exp_wv_cyc.pop_front());
            chk_eq("pulse_width", int'(pulse_width), exp_wv_w.pop_front());
         end
      end
      if (trigger) begin
         if (exp_trig_cyc.size() == 0) begin
            chk_eq("trigger_unexpected", 1, 0);
         end else begin
            chk_eq("trigger_cycle", cyc, exp_trig_cyc.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Called right after rst_sense is driven high: the next edge samples it.
   task automatic expect_release(input int w, input bit with_trig);
      exp_wv_cyc.push_back(cyc + 1 + SYNC);
      exp_wv_w.push_back(w);
      if (with_trig) exp_trig_cyc.push_back(cyc + 1 + SYNC + int'(delay));
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   // Low pulse sampled on exactly n edges, then released.
   task automatic pulse(input int n, input bit accept, input int w);
      rst_sense = 1'b0;
      tick(n);
      rst_sense = 1'b1;
      if (accept) expect_release(w, 1'b1);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (exp_wv_cyc.size() == 0 && exp_trig_cyc.size() == 0) break;
         tick(1);
      end
      chk_eq(tag, exp_wv_cyc.size() + exp_trig_cyc.size(), 0);
      tick(4);
   endtask

   initial begin
      rst       = 1'b1;
      rst_sense = 1'b1;
      arm       = 1'b0;
      abort     = 1'b0;
      min_width = 8'd8;
      delay     = 8'd5;
      tick(3);
      chk_eq("reset_trigger", int'(trigger), 0);
      chk_eq("reset_busy", int'(busy), 0);
      chk_eq("reset_pulse_width", int'(pulse_width), 0);
      chk_eq("reset_width_valid", int'(width_valid), 0);
      rst = 1'b0;
      tick(2);

      // Nominal: 20-cycle pulse, delay 5.
      do_arm();
      chk_eq("busy_after_arm", int'(busy), 1);
      tick(3);
      pulse(20, 1'b1, 20);
      wait_drain("nominal_drain");
      chk_eq("busy_after_trigger", int'(busy), 0);

      // Short glitch rejected, then a real 10-cycle pulse.
      do_arm();
      tick(3);
      pulse(3, 1'b0, 0);
      tick(8);
      chk_eq("busy_after_glitch", int'(busy), 1);
      pulse(10, 1'b1, 10);
      wait_drain("glitch_drain");

      // Boundary: 7 rejected, exactly min_width accepted.
      do_arm();
      tick(3);
      pulse(7, 1'b0, 0);
      tick(8);
      pulse(8, 1'b1, 8);
      wait_drain("boundary_drain");

      // Zero delay with min_width 1 and 0.
      delay     = 8'd0;
      min_width = 8'd1;
      do_arm();
      tick(3);
      pulse(1, 1'b1, 1);
      wait_drain("zero_delay_drain");
      min_width = 8'd0;
      do_arm();
      tick(3);
      pulse(1, 1'b1, 1);
      wait_drain("minw0_drain");

      // Saturation on a 300-cycle pulse.
      min_width = 8'd8;
      delay     = 8'd3;
      do_arm();
      tick(3);
      pulse(300, 1'b1, 255);
      wait_drain("saturate_drain");

      // Abort during DELAY: width_valid already issued, trigger suppressed.
      delay = 8'd20;
      do_arm();
      tick(3);
      rst_sense = 1'b0;
      tick(10);
      rst_sense = 1'b1;
      expect_release(10, 1'b0);
      tick(5);
      chk_eq("busy_in_delay", int'(busy), 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk_eq("abort_busy", int'(busy), 0);
      chk_eq("abort_trigger", int'(trigger), 0);
      tick(30);
      chk_eq("abort_pulse_width_kept", int'(pulse_width), 10);
      wait_drain("abort_drain");

      // Abort and arm together in IDLE: abort wins.
      abort = 1'b1;
      arm   = 1'b1;
      tick(1);
      abort = 1'b0;
      arm   = 1'b0;
      chk_eq("abort_beats_arm", int'(busy), 0);
      pulse(10, 1'b0, 0);
      tick(30);

      // Reset during LOW: everything cleared, release ignored until re-armed.
      delay = 8'd4;
      do_arm();
      tick(3);
      rst_sense = 1'b0;
      tick(6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk_eq("rst_low_busy", int'(busy), 0);
      chk_eq("rst_low_trigger", int'(trigger), 0);
      chk_eq("rst_low_pulse_width", int'(pulse_width), 0);
      chk_eq("rst_low_width_valid", int'(width_valid), 0);
      tick(5);
      rst_sense = 1'b1;
      tick(30);
      chk_eq("rst_low_idle", int'(busy), 0);
      do_arm();
      tick(3);
      pulse(9, 1'b1, 9);
      wait_drain("rearm_drain");

      // Arm pulsed in LOW and DELAY: exactly one trigger.
      delay     = 8'd6;
      min_width = 8'd2;
      do_arm();
      tick(3);
      rst_sense = 1'b0;
      tick(4);
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
      tick(5);
      rst_sense = 1'b1;
      expect_release(10, 1'b1);
      tick(SYNC + 2);
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
      wait_drain("arm_ignored_drain");
      // No re-arm: a further pulse must produce nothing.
      pulse(10, 1'b0, 0);
      tick(30);
      chk_eq("no_rearm_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
